// File: rtl/bus_arbiter_gen3_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_gen3_if
// Request/response bundle between NUM_CH bus masters, the arbiter and the
// shared memory port.
//   ch_req/ch_we/ch_addr/ch_wdata : per-channel request, packed by channel
//   RAM_data_in                   : memory read data (one cycle after issue)
//   ch_ack/ch_rvalid/ch_rdata     : per-channel handshake and read return
//   system_address/memory_data_out/mem_we/bus_valid : registered memory side
// Modports: slave = arbiter side, master = requester/memory side.
// ----------------------------------------------------------------------------
interface bus_arbiter_gen3_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [DATA_W-1:0]        RAM_data_in;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [ADDR_W-1:0]        system_address;
    logic [DATA_W-1:0]        memory_data_out;
    logic                     mem_we;
    logic                     bus_valid;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, RAM_data_in,
        output ch_ack, ch_rdata, ch_rvalid,
               system_address, memory_data_out, mem_we, bus_valid
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, RAM_data_in,
        input  ch_ack, ch_rdata, ch_rvalid,
               system_address, memory_data_out, mem_we, bus_valid
    );
endinterface

// File: rtl/bus_arbiter_gen3.sv
// ----------------------------------------------------------------------------
// bus_arbiter_gen3
// Shares one memory port among NUM_CH masters. With VIDEO_SLOT_EN=1 every
// second slot is an unconditional read for channel 0 and the remaining slots
// are round-robin among channels 1..NUM_CH-1; with VIDEO_SLOT_EN=0 every
// slot is round-robin among all channels. Read data returns one cycle after
// issue into the owner's ch_rdata register.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bus_arbiter_gen3_if.slave (requests, acks, read return, memory)
// ----------------------------------------------------------------------------
module bus_arbiter_gen3 #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned VIDEO_SLOT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_gen3_if.slave bus
);
    localparam int unsigned CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int unsigned FIRST_ELIG = (VIDEO_SLOT_EN != 0) ? 1 : 0;
    localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ELIG_MASK =
        (VIDEO_SLOT_EN != 0) ? {{(NUM_CH-1){1'b1}}, 1'b0} : {NUM_CH{1'b1}};

    typedef enum logic {
        SLOT_ARB   = 1'b0,
        SLOT_VIDEO = 1'b1
    } slot_e;

    slot_e phase;
    slot_e phase_nxt;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_nxt;
    logic [NUM_CH-1:0] elig_req;
    logic              grant_hit;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W:0]     cand;

    logic              issue;
    logic [CH_W-1:0]   sel_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0]        system_address_q;
    logic [DATA_W-1:0]        memory_data_out_q;
    logic                     mem_we_q;
    logic                     bus_valid_q;
    logic [NUM_CH-1:0]        ch_ack_q;
    logic [NUM_CH-1:0]        ch_rvalid_q;
    logic [NUM_CH*DATA_W-1:0] ch_rdata_q;
    logic                     rd_pend;
    logic [CH_W-1:0]          rd_owner;

    // Slot state register
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= SLOT_ARB;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Slot next-state: alternate only when the video slot is enabled
    always_comb begin
        phase_nxt = SLOT_ARB;
        if (VIDEO_SLOT_EN != 0 && phase == SLOT_ARB) begin
            phase_nxt = SLOT_VIDEO;
        end
    end

    assign elig_req = bus.ch_req & ELIG_MASK;

    // First eligible requester at or after rr_ptr, wrapping
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end
            if (!grant_hit && elig_req[cand[CH_W-1:0]]) begin
                grant_hit = 1'b1;
                grant_idx = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        if (32'(grant_idx) == NUM_CH - 1) begin
            rr_nxt = CH_W'(FIRST_ELIG);
        end else begin
            rr_nxt = grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= CH_W'(FIRST_ELIG);
        end else if (phase == SLOT_ARB && grant_hit) begin
            rr_ptr <= rr_nxt;
        end
    end

    // Slot output decode: which channel (if any) is issued this cycle
    always_comb begin
        issue   = 1'b0;
        sel_idx = '0;
        sel_we  = 1'b0;
        unique case (phase)
            SLOT_VIDEO: begin
                // Video read for channel 0 ignores its req/we
                issue   = 1'b1;
                sel_idx = '0;
                sel_we  = 1'b0;
            end
            default: begin
                issue   = grant_hit;
                sel_idx = grant_idx;
                sel_we  = grant_hit & bus.ch_we[grant_idx];
            end
        endcase
    end

    assign sel_addr  = bus.ch_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.ch_wdata[32'(sel_idx)*DATA_W +: DATA_W];

    // Issue registers and read-return capture
    always_ff @(posedge clk) begin
        if (reset) begin
            system_address_q  <= '0;
            memory_data_out_q <= '0;
            mem_we_q          <= 1'b0;
            bus_valid_q       <= 1'b0;
            ch_ack_q          <= '0;
            ch_rvalid_q       <= '0;
            ch_rdata_q        <= '0;
            rd_pend           <= 1'b0;
            rd_owner          <= '0;
        end else begin
            ch_ack_q    <= '0;
            ch_rvalid_q <= '0;
            if (issue) begin
                system_address_q <= sel_addr;
                if (sel_we) begin
                    memory_data_out_q <= sel_wdata;
                end
                mem_we_q          <= sel_we;
                bus_valid_q       <= 1'b1;
                ch_ack_q[sel_idx] <= 1'b1;
                rd_pend           <= ~sel_we;
                rd_owner          <= sel_idx;
            end else begin
                mem_we_q    <= 1'b0;
                bus_valid_q <= 1'b0;
                rd_pend     <= 1'b0;
            end
            // Reset clears rd_pend, so a read in flight at reset never returns
            if (rd_pend) begin
                ch_rdata_q[32'(rd_owner)*DATA_W +: DATA_W] <= bus.RAM_data_in;
                ch_rvalid_q[rd_owner]                      <= 1'b1;
            end
        end
    end

    assign bus.system_address  = system_address_q;
    assign bus.memory_data_out = memory_data_out_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.bus_valid       = bus_valid_q;
    assign bus.ch_ack          = ch_ack_q;
    assign bus.ch_rvalid       = ch_rvalid_q;
    assign bus.ch_rdata        = ch_rdata_q;
endmodule

// File: tb/tb_bus_arbiter_gen3.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_gen3
// Directed bench for bus_arbiter_gen3: a vector table on the default build
// (2 channels, video slot on), plus round-robin sequences on a 4-channel
// video build and a 3-channel all-arbitrated build.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_gen3;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic rst_c;
    int unsigned errors = 0;
    int unsigned checks = 0;

    bus_arbiter_gen3_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8)) if_a ();
    bus_arbiter_gen3_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8)) if_b ();
    bus_arbiter_gen3_if #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8)) if_c ();

    bus_arbiter_gen3 #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .VIDEO_SLOT_EN(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
    bus_arbiter_gen3 #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .VIDEO_SLOT_EN(1))
        dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));
    bus_arbiter_gen3 #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8), .VIDEO_SLOT_EN(0))
        dut_c (.clk(clk), .reset(rst_c), .bus(if_c.slave));

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [15:0] addr1;
        logic [7:0]  wdata1;
        logic [7:0]  ram;
        logic [1:0]  ack;
        logic        vld;
        logic        mwe;
        logic [15:0] saddr;
        logic [7:0]  dout;
        logic [1:0]  rv;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] req, input logic [1:0] we,
        input logic [15:0] a1, input logic [7:0] wd1, input logic [7:0] ram,
        input logic [1:0] ack, input logic vld, input logic mwe,
        input logic [15:0] sa, input logic [7:0] dout, input logic [1:0] rv,
        input logic [7:0] rd0, input logic [7:0] rd1);
        vec_t v;
        v.rst = rst;   v.req = req;  v.we = we;     v.addr1 = a1;
        v.wdata1 = wd1; v.ram = ram; v.ack = ack;   v.vld = vld;
        v.mwe = mwe;   v.saddr = sa; v.dout = dout; v.rv = rv;
        v.rd0 = rd0;   v.rd1 = rd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int b_ch[8] = '{1, 0, 2, 0, 3, 0, 1, 0};
    int c_ch[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.ch_req = '0; if_a.ch_we = '0; if_a.ch_addr = '0; if_a.ch_wdata = '0; if_a.RAM_data_in = '0;
        if_b.ch_req = '0; if_b.ch_we = '0; if_b.ch_addr = '0; if_b.ch_wdata = '0; if_b.RAM_data_in = '0;
        if_c.ch_req = '0; if_c.ch_we = '0; if_c.ch_addr = '0; if_c.ch_wdata = '0; if_c.RAM_data_in = '0;

        //            rst req   we    addr1     wd1    ram  | ack  v  we  saddr     dout   rv    rd0    rd1
        vecs[0]  = mk(1, 2'b00, 2'b00, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00, 8'h00);
        vecs[1]  = mk(1, 2'b00, 2'b00, 16'h0000, 8'h00, 8'h00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00, 8'h00);
        vecs[2]  = mk(0, 2'b10, 2'b00, 16'h4000, 8'h00, 8'h00, 2'b10, 1, 0, 16'h4000, 8'h00, 2'b00, 8'h00, 8'h00);
        vecs[3]  = mk(0, 2'b00, 2'b00, 16'h4000, 8'h00, 8'hA5, 2'b01, 1, 0, 16'h1234, 8'h00, 2'b10, 8'h00, 8'hA5);
        vecs[4]  = mk(0, 2'b00, 2'b00, 16'h4000, 8'h00, 8'h11, 2'b00, 0, 0, 16'h1234, 8'h00, 2'b01, 8'h11, 8'hA5);
        vecs[5]  = mk(0, 2'b10, 2'b10, 16'h4002, 8'h3C, 8'h00, 2'b01, 1, 0, 16'h1234, 8'h00, 2'b00, 8'h11, 8'hA5);
        vecs[6]  = mk(0, 2'b10, 2'b10, 16'h4002, 8'h3C, 8'h22, 2'b10, 1, 1, 16'h4002, 8'h3C, 2'b01, 8'h22, 8'hA5);
        vecs[7]  = mk(0, 2'b01, 2'b01, 16'h4002, 8'h3C, 8'h33, 2'b01, 1, 0, 16'h1234, 8'h3C, 2'b00, 8'h22, 8'hA5);
        vecs[8]  = mk(0, 2'b01, 2'b01, 16'h4002, 8'h3C, 8'h44, 2'b00, 0, 0, 16'h1234, 8'h3C, 2'b01, 8'h44, 8'hA5);
        vecs[9]  = mk(0, 2'b10, 2'b00, 16'h4010, 8'h3C, 8'h00, 2'b01, 1, 0, 16'h1234, 8'h3C, 2'b00, 8'h44, 8'hA5);
        vecs[10] = mk(0, 2'b10, 2'b00, 16'h4010, 8'h3C, 8'h55, 2'b10, 1, 0, 16'h4010, 8'h3C, 2'b01, 8'h55, 8'hA5);
        vecs[11] = mk(1, 2'b00, 2'b00, 16'h4010, 8'h3C, 8'h66, 2'b00, 0, 0, 16'h0000, 8'h00, 2'b00, 8'h00, 8'h00);
        vecs[12] = mk(0, 2'b10, 2'b00, 16'h4020, 8'h00, 8'h77, 2'b10, 1, 0, 16'h4020, 8'h00, 2'b00, 8'h00, 8'h00);
        vecs[13] = mk(0, 2'b00, 2'b00, 16'h4020, 8'h00, 8'h88, 2'b01, 1, 0, 16'h1234, 8'h00, 2'b10, 8'h00, 8'h88);
        vecs[14] = mk(0, 2'b00, 2'b00, 16'h4020, 8'h00, 8'h99, 2'b00, 0, 0, 16'h1234, 8'h00, 2'b01, 8'h99, 8'h88);

        for (int i = 0; i < NV; i++) begin
            rst_a            = vecs[i].rst;
            if_a.ch_req      = vecs[i].req;
            if_a.ch_we       = vecs[i].we;
            if_a.ch_addr     = {vecs[i].addr1, 16'h1234};
            if_a.ch_wdata    = {vecs[i].wdata1, 8'hEE};
            if_a.RAM_data_in = vecs[i].ram;
            tick();
            check($sformatf("v%0d ch_ack", i),          32'(if_a.ch_ack),          32'(vecs[i].ack));
            check($sformatf("v%0d bus_valid", i),       32'(if_a.bus_valid),       32'(vecs[i].vld));
            check($sformatf("v%0d mem_we", i),          32'(if_a.mem_we),          32'(vecs[i].mwe));
            check($sformatf("v%0d system_address", i),  32'(if_a.system_address),  32'(vecs[i].saddr));
            check($sformatf("v%0d memory_data_out", i), 32'(if_a.memory_data_out), 32'(vecs[i].dout));
            check($sformatf("v%0d ch_rvalid", i),       32'(if_a.ch_rvalid),       32'(vecs[i].rv));
            check($sformatf("v%0d ch_rdata0", i),       32'(if_a.ch_rdata[7:0]),   32'(vecs[i].rd0));
            check($sformatf("v%0d ch_rdata1", i),       32'(if_a.ch_rdata[15:8]),  32'(vecs[i].rd1));
        end

        // Round-robin with video slot (4 ch) and without (3 ch)
        if_b.ch_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        if_c.ch_addr = {16'h2002, 16'h2001, 16'h2000};
        tick();
        check("b reset ack", 32'(if_b.ch_ack), 32'h0);
        check("c reset valid", 32'(if_c.bus_valid), 32'h0);
        rst_b = 1'b0;
        rst_c = 1'b0;
        if_b.ch_req = 4'b1110;
        if_c.ch_req = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("b%0d ch_ack", i), 32'(if_b.ch_ack), 32'(1) << b_ch[i]);
            check($sformatf("b%0d system_address", i), 32'(if_b.system_address), 32'h1000 + 32'(b_ch[i]));
            check($sformatf("b%0d bus_valid", i), 32'(if_b.bus_valid), 32'h1);
            if (i < 6) begin
                check($sformatf("c%0d ch_ack", i), 32'(if_c.ch_ack), 32'(1) << c_ch[i]);
                check($sformatf("c%0d system_address", i), 32'(if_c.system_address), 32'h2000 + 32'(c_ch[i]));
                check($sformatf("c%0d mem_we", i), 32'(if_c.mem_we), 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
